// File: rtl/hold24_drain.sv
// Consumer end of the 24-bit hold-register chain.
// Two-entry skid FIFO feeding a valid/ready stream with block framing.
module hold24_drain #(
  parameter int N         = 24,
  parameter int DEPTH     = 2,
  parameter int BLOCK_LEN = 16,
  parameter int RELU      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [N-1:0] in_data,
  input  logic                in_valid,
  output logic                hold,
  output logic signed [N-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [15:0]         word_cnt
);

  localparam logic [15:0] LAST = 16'(BLOCK_LEN - 1);
  localparam logic [1:0]  FULL = 2'(DEPTH);

  logic signed [N-1:0] mem [2];
  logic                wp;
  logic                rp;
  logic [1:0]          count;
  logic                push;
  logic                pop;
  logic signed [N-1:0] wdata;

  assign hold      = (count == FULL);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rp];
  assign out_last  = out_valid & (word_cnt == LAST);

  assign push = in_valid & ~hold;
  assign pop  = out_valid & out_ready;

  // Negative words clamp to zero on capture when ReLU is enabled.
  assign wdata = ((RELU != 0) && in_data[N-1]) ? '0 : in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      count    <= 2'd0;
      word_cnt <= 16'd0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
        if (word_cnt == LAST) word_cnt <= 16'd0;
        else                  word_cnt <= word_cnt + 16'd1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_hold24_drain.sv
// Directed bench for hold24_drain: default, ReLU/BLOCK_LEN=4
// and BLOCK_LEN=1 instances.
module tb_hold24_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] d0, d1;
  logic        v0, v1, r0, r1;
  logic [23:0] o0, o1, o2;
  logic        h0, h1, h2;
  logic        ov0, ov1, ov2;
  logic        ol0, ol1, ol2;
  logic [15:0] wc0, wc1, wc2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hold24_drain u0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0),
    .hold(h0), .out_data(o0), .out_valid(ov0), .out_ready(r0),
    .out_last(ol0), .word_cnt(wc0)
  );

  hold24_drain #(.BLOCK_LEN(4), .RELU(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1),
    .hold(h1), .out_data(o1), .out_valid(ov1), .out_ready(r1),
    .out_last(ol1), .word_cnt(wc1)
  );

  hold24_drain #(.BLOCK_LEN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1),
    .hold(h2), .out_data(o2), .out_valid(ov2), .out_ready(r1),
    .out_last(ol2), .word_cnt(wc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [23:0] dat,
                      input logic vld, input logic hld);
    chk({tag, ".data"}, 32'(o0), 32'(dat));
    chk({tag, ".valid"}, 32'(ov0), 32'(vld));
    chk({tag, ".hold"}, 32'(h0), 32'(hld));
  endtask

  initial begin
    int sent;
    int rcv;
    bit push;
    bit pop;
    rst_n = 1'b0;
    {d0, d1} = '0;
    {v0, v1, r0, r1} = '0;

    // Reset then idle
    tick();
    tick();
    chk("rst.wc", 32'(wc0), 32'd0);
    chk("rst.last", 32'(ol0), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk0("idle", 24'h0, 1'b0, 1'b0);
      chk("idle.wc", 32'(wc0), 32'd0);
    end

    // Pass-through
    r0 = 1'b1;
    v0 = 1'b1;
    d0 = 24'h000005; tick(); chk0("pt0", 24'h000005, 1'b1, 1'b0);
    d0 = 24'hFFFFFD; tick(); chk0("pt1", 24'hFFFFFD, 1'b1, 1'b0);
    d0 = 24'h7FFFFF; tick(); chk0("pt2", 24'h7FFFFF, 1'b1, 1'b0);
    v0 = 1'b0;       tick(); chk("pt.drain", 32'(ov0), 32'd0);
    chk("pt.wc", 32'(wc0), 32'd3);

    // Backpressure
    r0 = 1'b0;
    v0 = 1'b1;
    d0 = 24'h000011; tick(); chk0("bp0", 24'h000011, 1'b1, 1'b0);
    d0 = 24'h000022; tick(); chk0("bp1", 24'h000011, 1'b1, 1'b1);
    d0 = 24'h000033; tick(); chk0("bp2", 24'h000011, 1'b1, 1'b1);
    r0 = 1'b1;       tick(); chk0("bp3", 24'h000022, 1'b1, 1'b0);
    tick();                  chk0("bp4", 24'h000033, 1'b1, 1'b0);
    v0 = 1'b0;       tick(); chk("bp.drain", 32'(ov0), 32'd0);
    chk("bp.wc", 32'(wc0), 32'd6);

    // Reset mid-stream with two words buffered
    r0 = 1'b0;
    v0 = 1'b1;
    d0 = 24'h0000AA; tick();
    d0 = 24'h0000BB; tick(); chk0("mr.full", 24'h0000AA, 1'b1, 1'b1);
    rst_n = 1'b0;
    v0 = 1'b0;
    tick();
    chk0("mr.rst", 24'h0, 1'b0, 1'b0);
    chk("mr.wc", 32'(wc0), 32'd0);
    rst_n = 1'b1;
    r0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr.after", 32'(ov0), 32'd0);
    end

    // ReLU on capture
    r1 = 1'b1;
    v1 = 1'b1;
    d1 = 24'hFFFFFF; tick(); chk("relu.neg", 32'(o1), 32'h0);
    chk("relu.v0", 32'(ov1), 32'd1);
    d1 = 24'h000007; tick(); chk("relu.pos", 32'(o1), 32'h7);
    v1 = 1'b0; tick();

    // Block framing, BLOCK_LEN=4, random ready
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sent = 0;
    rcv = 0;
    for (int c = 0; c < 300 && rcv < 10; c++) begin
      v1 = (sent < 10);
      d1 = 24'(sent + 1);
      r1 = 1'($urandom_range(0, 1));
      push = v1 && !h1;
      pop = ov1 && r1;
      chk("bl1.last", 32'(ol2), 32'(ov2));
      if (pop) begin
        chk("blk.data", 32'(o1), 32'(rcv + 1));
        chk("blk.last", 32'(ol1), 32'(((rcv + 1) % 4) == 0));
        chk("blk.wc", 32'(wc1), 32'(rcv % 4));
        rcv++;
      end
      if (push) sent++;
      tick();
    end
    chk("blk.count", 32'(rcv), 32'd10);
    v1 = 1'b0;
    r1 = 1'b1;
    tick();
    chk("blk.empty", 32'(ov1), 32'd0);
    chk("blk.wcend", 32'(wc1), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
